// File: rtl/palindrome_window.sv
`default_nettype none
// ============================================================================
// Module  : palindrome_window
// Brief   : Sliding-window serial palindrome / complement-palindrome detector
//           with valid qualifier, synchronous clear and saturating match count.
// Revision: 1.0 - initial release
// ============================================================================
module palindrome_window #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_i,
    input  logic             x_valid_i,
    input  logic             clear_i,
    input  logic             mode_i,
    output logic             palindrome_o,
    output logic             window_full_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int                 c_FILL_W   = $clog2(WIDTH);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(WIDTH - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(WIDTH - 2);
    localparam int                 c_HALF     = WIDTH / 2;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [WIDTH-2:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic [0:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic [WIDTH-1:0]    w_win;
    logic [c_HALF-1:0]   w_pair;
    logic                w_mid_ok;
    logic                w_match;
    logic                w_pal;

    assign w_accept = x_valid_i & ~clear_i;

    // Newest bit sits at index 0, oldest history bit at index WIDTH-1.
    assign w_win = {r_hist, x_i};

    generate
        for (genvar k = 0; k < c_HALF; k++) begin : g_pair
            assign w_pair[k] = ~(w_win[k] ^ w_win[WIDTH-1-k] ^ mode_i);
        end

        if (WIDTH % 2 == 1) begin : g_odd
            // The middle bit pairs with itself, so complement mode can never match.
            assign w_mid_ok = (w_win[c_HALF] == (w_win[c_HALF] ^ mode_i));
        end else begin : g_even
            assign w_mid_ok = 1'b1;
        end
    endgenerate

    assign w_match = (&w_pair) & w_mid_ok;
    assign w_pal   = x_valid_i & window_full_o & ~clear_i & w_match;

    assign palindrome_o  = w_pal;
    assign window_full_o = (r_state == S_RUN);
    assign match_cnt_o   = r_cnt;

    generate
        if (WIDTH == 2) begin : g_hist_w2
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_hist <= '0;
                end else if (clear_i) begin
                    r_hist <= '0;
                end else if (w_accept) begin
                    r_hist <= x_i;
                end
            end
        end else begin : g_hist_wn
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_hist <= '0;
                end else if (clear_i) begin
                    r_hist <= '0;
                end else if (w_accept) begin
                    r_hist <= {r_hist[WIDTH-3:0], x_i};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill  <= '0;
            r_state <= S_FILL;
        end else if (clear_i) begin
            r_fill  <= '0;
            r_state <= S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (x_valid_i) begin
                        r_fill <= r_fill + 1'b1;
                        if (r_fill == c_FILL_LAST) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_fill <= c_FILL_MAX;
                end
                default: begin
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_pal && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palindrome_window.sv
`default_nettype none
// ============================================================================
// Module  : tb_palindrome_window
// Brief   : Self-checking bench: three detector instances against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_palindrome_window;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0, x_valid = 1'b0, clear = 1'b0, mode = 1'b0;

    logic        d_pal_a, d_wf_a, d_pal_b, d_wf_b, d_pal_c, d_wf_c;
    logic [15:0] d_cnt_a, d_cnt_b;
    logic [1:0]  d_cnt_c;

    int n_pass = 0;
    int n_total = 0;

    // Model: every bit accepted since the last clear/reset, plus per-instance counts.
    bit acc[$];
    int m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;

    always #5 clk = ~clk;

    palindrome_window #(.WIDTH(3), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .x_i(x), .x_valid_i(x_valid), .clear_i(clear),
        .mode_i(mode), .palindrome_o(d_pal_a), .window_full_o(d_wf_a), .match_cnt_o(d_cnt_a));
    palindrome_window #(.WIDTH(4), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .x_i(x), .x_valid_i(x_valid), .clear_i(clear),
        .mode_i(mode), .palindrome_o(d_pal_b), .window_full_o(d_wf_b), .match_cnt_o(d_cnt_b));
    palindrome_window #(.WIDTH(3), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .x_i(x), .x_valid_i(x_valid), .clear_i(clear),
        .mode_i(mode), .palindrome_o(d_pal_c), .window_full_o(d_wf_c), .match_cnt_o(d_cnt_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit exp_full(input int w);
        return reset && (acc.size() >= w - 1);
    endfunction

    function automatic bit exp_pal(input int w);
        bit win[32];
        if (!reset || !x_valid || clear || acc.size() < w - 1) return 1'b0;
        win[0] = x;
        for (int k = 1; k < w; k++) win[k] = acc[acc.size() - k];
        for (int k = 0; k < w; k++) begin
            if (win[k] != (win[w-1-k] ^ mode)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            acc.delete();
            m_cnt_a = 0; m_cnt_b = 0; m_cnt_c = 0;
        end else if (x_valid) begin
            if (exp_pal(3) && m_cnt_a < 65535) m_cnt_a++;
            if (exp_pal(4) && m_cnt_b < 65535) m_cnt_b++;
            if (exp_pal(3) && m_cnt_c < 3) m_cnt_c++;
            acc.push_back(x);
            if (acc.size() > 40) void'(acc.pop_front());
        end
    end

    always @(negedge clk) begin
        check("cmp_pal_a", {31'd0, d_pal_a}, {31'd0, exp_pal(3)});
        check("cmp_wf_a",  {31'd0, d_wf_a},  {31'd0, exp_full(3)});
        check("cmp_cnt_a", {16'd0, d_cnt_a}, m_cnt_a);
        check("cmp_pal_b", {31'd0, d_pal_b}, {31'd0, exp_pal(4)});
        check("cmp_wf_b",  {31'd0, d_wf_b},  {31'd0, exp_full(4)});
        check("cmp_cnt_b", {16'd0, d_cnt_b}, m_cnt_b);
        check("cmp_pal_c", {31'd0, d_pal_c}, {31'd0, exp_pal(3)});
        check("cmp_wf_c",  {31'd0, d_wf_c},  {31'd0, exp_full(3)});
        check("cmp_cnt_c", {30'd0, d_cnt_c}, m_cnt_c);
    end

    task automatic drive(input bit xb, input bit v, input bit c, input bit m);
        @(posedge clk);
        #1;
        x = xb; x_valid = v; clear = c; mode = m;
        @(negedge clk);
    endtask

    initial begin
        bit s1[6] = '{1, 0, 1, 1, 0, 1};
        bit p1[6] = '{0, 0, 1, 0, 0, 1};

        // Reset state
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        check("rst_pal", {31'd0, d_pal_a}, 0);
        check("rst_wf",  {31'd0, d_wf_a}, 0);
        check("rst_cnt", {16'd0, d_cnt_a}, 0);
        x_valid = 1'b0;
        reset = 1'b1;

        // Basic stream, mode 0
        for (int i = 0; i < 6; i++) begin
            drive(s1[i], 1, 0, 0);
            check("t1_pal", {31'd0, d_pal_a}, {31'd0, p1[i]});
            if (i == 1) check("t1_wf_before", {31'd0, d_wf_a}, 0);
            if (i == 2) check("t1_wf_after",  {31'd0, d_wf_a}, 1);
        end
        drive(0, 0, 0, 0);
        check("t1_cnt", {16'd0, d_cnt_a}, 2);

        // Idle cycles hold history
        drive(0, 1, 1, 0);
        drive(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 0, 0, 0);
            check("t2_idle_pal", {31'd0, d_pal_a}, 0);
        end
        drive(0, 1, 0, 0);
        check("t2_pal_b0", {31'd0, d_pal_a}, 0);
        drive(1, 1, 0, 0);
        check("t2_pal_b1", {31'd0, d_pal_a}, 1);

        // WIDTH=4 complement / plain, same-cycle mode change
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        check("t3_0011_m1", {31'd0, d_pal_b}, 1);
        check("t3_w3_m1",   {31'd0, d_pal_a}, 0);
        #1 mode = 1'b0;
        #1 check("t3_0011_m0", {31'd0, d_pal_b}, 0);
        drive(0, 1, 1, 0);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        check("t3_1001_m0", {31'd0, d_pal_b}, 1);
        #1 mode = 1'b1;
        #1 check("t3_1001_m1", {31'd0, d_pal_b}, 0);
        for (int i = 0; i < 5; i++) begin
            drive(i[1], 1, 0, 1);
            check("t3_w3_m1_never", {31'd0, d_pal_a}, 0);
        end

        // Clear has priority over an accepted bit
        drive(0, 1, 1, 0);
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        check("t4_cnt_pre", {16'd0, d_cnt_a}, 1);
        check("t4_pal_clr", {31'd0, d_pal_a}, 0);
        drive(0, 1, 0, 0);
        check("t4_cnt_post", {16'd0, d_cnt_a}, 0);
        check("t4_wf_post",  {31'd0, d_wf_a}, 0);
        check("t4_pal_n1",   {31'd0, d_pal_a}, 0);
        drive(1, 1, 0, 0);
        check("t4_pal_n2",   {31'd0, d_pal_a}, 0);

        // Saturating counter, CNT_W=2
        drive(0, 1, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            drive(1, 1, 0, 0);
            check("t5_pal", {31'd0, d_pal_c}, (i >= 3) ? 1 : 0);
            if (i >= 4) check("t5_cnt", {30'd0, d_cnt_c}, (i - 3 > 3) ? 3 : i - 3);
        end
        drive(0, 0, 0, 0);
        check("t5_cnt_end", {30'd0, d_cnt_c}, 3);

        // Asynchronous reset mid-stream
        drive(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) drive(s1[i], 1, 0, 0);
        @(posedge clk);
        #1 x = 1'b0; x_valid = 1'b1; clear = 1'b0; mode = 1'b0;
        #1;
        check("t6_pal_pre", {31'd0, d_pal_a}, 1);
        check("t6_cnt_pre", {16'd0, d_cnt_a}, 2);
        check("t6_wf_pre",  {31'd0, d_wf_a}, 1);
        #1 reset = 1'b0;
        #1;
        check("t6_pal_rst", {31'd0, d_pal_a}, 0);
        check("t6_cnt_rst", {16'd0, d_cnt_a}, 0);
        check("t6_wf_rst",  {31'd0, d_wf_a}, 0);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 1, 0, 0);
        check("t6_r1", {31'd0, d_pal_a}, 0);
        drive(0, 1, 0, 0);
        check("t6_r2", {31'd0, d_pal_a}, 0);
        drive(1, 1, 0, 0);
        check("t6_r3", {31'd0, d_pal_a}, 1);
        drive(0, 0, 0, 0);
        check("t6_cnt_end", {16'd0, d_cnt_a}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
